// File: rtl/cam_alloc.sv
// CAM with internal lowest-free-slot allocation, duplicate rejection, delete by address,
// registered lookup and occupancy tracking. Optional macro CAM_ALLOC_REPLACE_EN enables round-robin replacement when full.

module cam_alloc_chk #(
  parameter int ENTRIES_N = 32,
  parameter int CNT_W     = 6
) (
  input logic                 clk,
  input logic                 nreset,
  input logic [ENTRIES_N-1:0] valid,
  input logic [CNT_W-1:0]     count,
  input logic                 lkp_multi
);

  a_count_popcount: assert property (@(posedge clk) disable iff (!nreset)
    count == CNT_W'($countones(valid)));

  a_no_multi_hit: assert property (@(posedge clk) disable iff (!nreset)
    !lkp_multi);

endmodule

module cam_alloc #(
  parameter  int ENTRIES_N = 32,
  parameter  int KEY_W     = 8,
  localparam int ADDR_W    = $clog2(ENTRIES_N),
  localparam int CNT_W     = $clog2(ENTRIES_N + 1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              ins_i,
  input  logic [KEY_W-1:0]  ins_key_i,
  output logic              ins_ack_o,
  output logic              ins_ok_o,
  output logic [ADDR_W-1:0] ins_addr_o,
  output logic              ins_dup_o,
  input  logic              del_i,
  input  logic [ADDR_W-1:0] del_addr_i,
  input  logic              lkp_i,
  input  logic [KEY_W-1:0]  lkp_key_i,
  output logic              lkp_valid_o,
  output logic              lkp_hit_o,
  output logic [ADDR_W-1:0] lkp_addr_o,
  output logic              lkp_multi_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(ENTRIES_N);
  localparam logic [ADDR_W:0]   ENTRIES_V = (ADDR_W + 1)'(ENTRIES_N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES_N - 1);

  function automatic logic [ADDR_W-1:0] prio_enc(input logic [ENTRIES_N-1:0] vec);
    logic [ADDR_W-1:0] idx;
    idx = {ADDR_W{1'b0}};
    for (int i = ENTRIES_N - 1; i >= 0; i--) begin
      idx = vec[i] ? ADDR_W'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [ENTRIES_N-1:0] vec);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      multi = multi | (seen & vec[i]);
      seen  = seen | vec[i];
    end
    return multi;
  endfunction

  logic [ENTRIES_N-1:0] valid_r;
  logic [ENTRIES_N-1:0] valid_nxt_s;
  logic [KEY_W-1:0]     key_r [ENTRIES_N];
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_nxt_s;

  logic [ENTRIES_N-1:0] ins_match_s;
  logic [ENTRIES_N-1:0] lkp_match_s;
  logic                 full_s;
  logic                 ins_dup_s;
  logic                 alloc_s;
  logic                 repl_s;
  logic                 wr_s;
  logic [ADDR_W-1:0]    victim_s;
  logic [ADDR_W-1:0]    wr_addr_s;
  logic [ADDR_W-1:0]    ins_addr_s;
  logic                 del_eff_s;

  logic                 ins_ack_r;
  logic                 ins_ok_r;
  logic                 ins_dup_r;
  logic [ADDR_W-1:0]    ins_addr_r;
  logic                 lkp_valid_r;
  logic                 lkp_hit_r;
  logic [ADDR_W-1:0]    lkp_addr_r;
  logic                 lkp_multi_r;

  // Per-entry key comparison against the pre-update table for both request ports.
  always_comb begin
    ins_match_s = {ENTRIES_N{1'b0}};
    lkp_match_s = {ENTRIES_N{1'b0}};
    for (int i = 0; i < ENTRIES_N; i++) begin
      ins_match_s[i] = valid_r[i] & (key_r[i] == ins_key_i);
      lkp_match_s[i] = valid_r[i] & (key_r[i] == lkp_key_i);
    end
  end

  assign full_s    = (count_r == FULL_CNT);
  assign ins_dup_s = |ins_match_s;
  assign alloc_s   = ins_i & ~ins_dup_s & ~full_s;

`ifdef CAM_ALLOC_REPLACE_EN
  logic [ADDR_W-1:0] rr_ptr_r;

  assign repl_s   = ins_i & ~ins_dup_s & full_s;
  assign victim_s = rr_ptr_r;

  // Round-robin victim pointer, advanced once per replacement.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_r <= {ADDR_W{1'b0}};
    end else if (repl_s) begin
      rr_ptr_r <= (rr_ptr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : rr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  assign repl_s   = 1'b0;
  assign victim_s = {ADDR_W{1'b0}};
`endif

  assign wr_s      = alloc_s | repl_s;
  assign wr_addr_s = repl_s ? victim_s : prio_enc(~valid_r);

  // Delete counts only for an in-range valid target; a same-cycle replacement of that entry wins.
  always_comb begin
    del_eff_s = 1'b0;
    if (del_i && ({1'b0, del_addr_i} < ENTRIES_V)) begin
      del_eff_s = valid_r[del_addr_i] & ~(repl_s & (del_addr_i == victim_s));
    end else begin
      del_eff_s = 1'b0;
    end
  end

  // Next valid vector and occupancy.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int i = 0; i < ENTRIES_N; i++) begin
      valid_nxt_s[i] = (valid_r[i] & ~(del_eff_s & (del_addr_i == ADDR_W'(i))))
                     | (wr_s & (wr_addr_s == ADDR_W'(i)));
    end
    count_nxt_s = count_r + CNT_W'(alloc_s) - CNT_W'(del_eff_s);
  end

  // Insert response address: duplicate location, written slot, or zero on reject.
  always_comb begin
    ins_addr_s = {ADDR_W{1'b0}};
    if (ins_dup_s) begin
      ins_addr_s = prio_enc(ins_match_s);
    end else if (wr_s) begin
      ins_addr_s = wr_addr_s;
    end else begin
      ins_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Valid bits and occupancy counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_r <= {ENTRIES_N{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Key storage carries no reset; an entry is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      key_r[wr_addr_s] <= ins_key_i;
    end
  end

  // Registered insert and lookup responses.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ins_ack_r   <= 1'b0;
      ins_ok_r    <= 1'b0;
      ins_dup_r   <= 1'b0;
      ins_addr_r  <= {ADDR_W{1'b0}};
      lkp_valid_r <= 1'b0;
      lkp_hit_r   <= 1'b0;
      lkp_addr_r  <= {ADDR_W{1'b0}};
      lkp_multi_r <= 1'b0;
    end else begin
      ins_ack_r   <= ins_i;
      ins_ok_r    <= wr_s;
      ins_dup_r   <= ins_i & ins_dup_s;
      ins_addr_r  <= ins_i ? ins_addr_s : {ADDR_W{1'b0}};
      lkp_valid_r <= lkp_i;
      lkp_hit_r   <= lkp_i & (|lkp_match_s);
      lkp_addr_r  <= lkp_i ? prio_enc(lkp_match_s) : {ADDR_W{1'b0}};
      lkp_multi_r <= lkp_i & more_than_one(lkp_match_s);
    end
  end

  assign ins_ack_o   = ins_ack_r;
  assign ins_ok_o    = ins_ok_r;
  assign ins_dup_o   = ins_dup_r;
  assign ins_addr_o  = ins_addr_r;
  assign lkp_valid_o = lkp_valid_r;
  assign lkp_hit_o   = lkp_hit_r;
  assign lkp_addr_o  = lkp_addr_r;
  assign lkp_multi_o = lkp_multi_r;
  assign count_o     = count_r;
  assign full_o      = (count_r == FULL_CNT);
  assign empty_o     = (count_r == {CNT_W{1'b0}});

  cam_alloc_chk #(
    .ENTRIES_N (ENTRIES_N),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk       (clk),
    .nreset    (nreset),
    .valid     (valid_r),
    .count     (count_r),
    .lkp_multi (lkp_multi_r)
  );

endmodule

// File: tb/tb_cam_alloc.sv
// Directed bench for cam_alloc (32 entries, 8-bit keys); follows CAM_ALLOC_REPLACE_EN when defined.

module tb_cam_alloc;

  localparam int N  = 32;
  localparam int KW = 8;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          nreset;
  logic          ins_i;
  logic [KW-1:0] ins_key_i;
  logic          ins_ack_o;
  logic          ins_ok_o;
  logic [AW-1:0] ins_addr_o;
  logic          ins_dup_o;
  logic          del_i;
  logic [AW-1:0] del_addr_i;
  logic          lkp_i;
  logic [KW-1:0] lkp_key_i;
  logic          lkp_valid_o;
  logic          lkp_hit_o;
  logic [AW-1:0] lkp_addr_o;
  logic          lkp_multi_o;
  logic          full_o;
  logic          empty_o;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cam_alloc #(.ENTRIES_N(N), .KEY_W(KW)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .ins_i       (ins_i),
    .ins_key_i   (ins_key_i),
    .ins_ack_o   (ins_ack_o),
    .ins_ok_o    (ins_ok_o),
    .ins_addr_o  (ins_addr_o),
    .ins_dup_o   (ins_dup_o),
    .del_i       (del_i),
    .del_addr_i  (del_addr_i),
    .lkp_i       (lkp_i),
    .lkp_key_i   (lkp_key_i),
    .lkp_valid_o (lkp_valid_o),
    .lkp_hit_o   (lkp_hit_o),
    .lkp_addr_o  (lkp_addr_o),
    .lkp_multi_o (lkp_multi_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ins(input string tag, input logic ok, input logic dup, input int addr);
    chk({tag, ".ack"}, 32'(ins_ack_o), 32'd1);
    chk({tag, ".ok"}, 32'(ins_ok_o), 32'(ok));
    chk({tag, ".dup"}, 32'(ins_dup_o), 32'(dup));
    chk({tag, ".addr"}, 32'(ins_addr_o), 32'(addr));
  endtask

  task automatic chk_lkp(input string tag, input logic hit, input int addr);
    chk({tag, ".vld"}, 32'(lkp_valid_o), 32'd1);
    chk({tag, ".hit"}, 32'(lkp_hit_o), 32'(hit));
    chk({tag, ".addr"}, 32'(lkp_addr_o), 32'(addr));
    chk({tag, ".multi"}, 32'(lkp_multi_o), 32'd0);
  endtask

  initial begin
    nreset = 1'b0; ins_i = 1'b0; ins_key_i = 8'h00; del_i = 1'b0; del_addr_i = 5'd0;
    lkp_i = 1'b0; lkp_key_i = 8'h00;
    #2;
    chk("rst.count", 32'(count_o), 32'd0);
    chk("rst.empty", 32'(empty_o), 32'd1);
    chk("rst.full", 32'(full_o), 32'd0);
    chk("rst.ack", 32'(ins_ack_o), 32'd0);
    chk("rst.lvld", 32'(lkp_valid_o), 32'd0);
    cyc; cyc;
    nreset = 1'b1;
    cyc;

    // three back-to-back inserts
    ins_i = 1'b1; ins_key_i = 8'h11; cyc; chk_ins("ins11", 1'b1, 1'b0, 0);
    ins_key_i = 8'h22; cyc; chk_ins("ins22", 1'b1, 1'b0, 1);
    ins_key_i = 8'h33; cyc; chk_ins("ins33", 1'b1, 1'b0, 2);
    chk("cnt3", 32'(count_o), 32'd3);
    chk("notempty", 32'(empty_o), 32'd0);
    ins_i = 1'b0; cyc;
    chk("ack_idle", 32'(ins_ack_o), 32'd0);

    // duplicate insert
    ins_i = 1'b1; ins_key_i = 8'h22; cyc; chk_ins("dup22", 1'b0, 1'b1, 1);
    chk("dup.cnt", 32'(count_o), 32'd3);
    ins_i = 1'b0;

    // lookups
    lkp_i = 1'b1; lkp_key_i = 8'h22; cyc; chk_lkp("lkp22", 1'b1, 1);
    lkp_key_i = 8'h44; cyc; chk_lkp("lkp44", 1'b0, 0);

    // delete + same-cycle lookup sees old table
    del_i = 1'b1; del_addr_i = 5'd1; lkp_key_i = 8'h22; cyc; chk_lkp("lkpdel", 1'b1, 1);
    chk("del.cnt", 32'(count_o), 32'd2);
    lkp_i = 1'b0; cyc;
    chk("del2.cnt", 32'(count_o), 32'd2);
    chk("idle.lvld", 32'(lkp_valid_o), 32'd0);
    chk("idle.lhit", 32'(lkp_hit_o), 32'd0);
    del_i = 1'b0;
    ins_i = 1'b1; ins_key_i = 8'h55; cyc; chk_ins("ins55", 1'b1, 1'b0, 1);
    chk("cnt3b", 32'(count_o), 32'd3);

    // fill remaining entries 3..31 with keys 0x63..0x7f
    for (int i = 3; i < N; i++) begin
      ins_key_i = KW'(8'h60 + i);
      cyc;
      chk_ins("fill", 1'b1, 1'b0, i);
    end
    ins_i = 1'b0;
    chk("full", 32'(full_o), 32'd1);
    chk("full.cnt", 32'(count_o), 32'd32);

`ifdef CAM_ALLOC_REPLACE_EN
    ins_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins_key_i = KW'(8'hA0 + i);
      cyc;
      chk_ins("repl", 1'b1, 1'b0, i);
      chk("repl.cnt", 32'(count_o), 32'd32);
    end
    ins_i = 1'b0;
    lkp_i = 1'b1; lkp_key_i = 8'h11; cyc; chk_lkp("old11", 1'b0, 0);
    lkp_key_i = 8'h55; cyc; chk_lkp("old55", 1'b0, 0);
    lkp_key_i = 8'hA1; cyc; chk_lkp("newA1", 1'b1, 1);
    lkp_i = 1'b0;
`else
    ins_i = 1'b1; ins_key_i = 8'hA5; cyc; chk_ins("insfull", 1'b0, 1'b0, 0);
    chk("insfull.cnt", 32'(count_o), 32'd32);
    ins_key_i = 8'h33; cyc; chk_ins("dupfull", 1'b0, 1'b1, 2);
    ins_key_i = 8'h99; del_i = 1'b1; del_addr_i = 5'd5; cyc;
    chk_ins("insdel", 1'b0, 1'b0, 0);
    chk("insdel.cnt", 32'(count_o), 32'd31);
    chk("insdel.full", 32'(full_o), 32'd0);
    del_i = 1'b0; cyc; chk_ins("ins99", 1'b1, 1'b0, 5);
    chk("ins99.cnt", 32'(count_o), 32'd32);
    chk("ins99.full", 32'(full_o), 32'd1);
    ins_i = 1'b0;
`endif

    // reset in the middle of traffic
    ins_i = 1'b1; ins_key_i = 8'hAB; lkp_i = 1'b1; lkp_key_i = 8'h70; cyc;
    chk("pre.ack", 32'(ins_ack_o), 32'd1);
    chk_lkp("pre.lkp", 1'b1, 16);
    #2 nreset = 1'b0;
    #1;
    chk("mid.ack", 32'(ins_ack_o), 32'd0);
    chk("mid.ok", 32'(ins_ok_o), 32'd0);
    chk("mid.lvld", 32'(lkp_valid_o), 32'd0);
    chk("mid.lhit", 32'(lkp_hit_o), 32'd0);
    chk("mid.laddr", 32'(lkp_addr_o), 32'd0);
    chk("mid.count", 32'(count_o), 32'd0);
    chk("mid.empty", 32'(empty_o), 32'd1);
    chk("mid.full", 32'(full_o), 32'd0);
    ins_i = 1'b0; lkp_i = 1'b0;
    cyc; cyc;
    nreset = 1'b1;
    cyc;
    chk("post.ack", 32'(ins_ack_o), 32'd0);
    chk("post.lvld", 32'(lkp_valid_o), 32'd0);
    lkp_i = 1'b1; lkp_key_i = 8'h70; cyc; chk_lkp("post.lkp", 1'b0, 0);
    lkp_i = 1'b0; cyc;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_alloc.md
Name: cam_alloc

Overview:
Parametrised content-addressable memory with internal slot allocation. It replaces the externally addressed CAM used in the lookup path.
- Insert picks the lowest free entry itself and rejects duplicate keys.
- Delete invalidates by address.
- Lookup is registered, returning hit, lowest matching address and a multi-hit flag one cycle later.
- Occupancy count and full/empty flags are provided for upstream flow control.

Parameters:
ENTRIES_N, 32, number of entries (>=2)
KEY_W, 8, key width in bits
ADDR_W, $clog2(ENTRIES_N), entry address width (derived, not overridable)
CNT_W, $clog2(ENTRIES_N+1), occupancy counter width (derived)

Ports:
clk  in  1  clock, all state on rising edge
nreset  in  1  asynchronous active-low reset
ins_i  in  1  insert request
ins_key_i  in  KEY_W  key to insert
ins_ack_o  out  1  insert response valid, one cycle after ins_i
ins_ok_o  out  1  insert succeeded (qualified by ins_ack_o)
ins_addr_o  out  ADDR_W  allocated address, or address of the existing duplicate
ins_dup_o  out  1  insert rejected: key already present
del_i  in  1  delete request
del_addr_i  in  ADDR_W  entry to invalidate
lkp_i  in  1  lookup request
lkp_key_i  in  KEY_W  lookup key
lkp_valid_o  out  1  lookup response valid, one cycle after lkp_i
lkp_hit_o  out  1  at least one valid entry matched
lkp_addr_o  out  ADDR_W  lowest matching index; 0 on miss
lkp_multi_o  out  1  more than one valid entry matched (integrity error)
full_o  out  1  all entries valid
empty_o  out  1  no entry valid
count_o  out  CNT_W  number of valid entries

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - all valid bits 0, count_o=0, empty_o=1, full_o=0.
  - all ack/valid/hit/ok/dup/multi outputs 0; address outputs 0.
  - Key storage is not reset.
- Reset mid-operation: in-flight responses are dropped; no ack is produced after reset release for requests issued before it.
- All request evaluation uses the table state sampled at the rising edge, i.e. before any same-cycle update.
- Insert, 1-cycle latency:
  - Duplicate: a valid entry's key equals ins_key_i -> no write; ins_ok_o=0, ins_dup_o=1, ins_addr_o=lowest matching index.
  - Full (no duplicate): no write; ins_ok_o=0, ins_dup_o=0, ins_addr_o=0.
  - Otherwise: write the key into the lowest-index free entry and set it valid; ins_ok_o=1, ins_addr_o=that index.
  - ins_ack_o pulses exactly one cycle per ins_i.
- Delete: takes effect at the next edge; clears the valid bit of del_addr_i. No response. Deleting an invalid entry, or del_addr_i>=ENTRIES_N, is a silent no-op with count unchanged.
- Lookup, 1-cycle latency:
  - Match = valid & (key==lkp_key_i) per entry; all outputs registered.
  - lkp_hit_o = OR of matches; lkp_addr_o = priority encode (lowest index); lkp_multi_o = more than one match.
  - lkp_hit_o, lkp_multi_o and lkp_addr_o are 0 when lkp_i was low.
- Simultaneous events in one cycle:
  - Insert + delete: full and duplicate checks use pre-delete state, so insert while full plus a delete -> insert rejected, delete applied.
  - A normal insert target is free and a delete target must be valid, so they never conflict.
  - Lookup + insert/delete of the same key: the lookup sees the old table.
  - count_o next = count + ins_success - del_effective. Simultaneous success and effective delete leaves count unchanged.
- full_o/empty_o are derived combinationally from the registered count (count==ENTRIES_N / count==0).
- No wrap-around: the allocator always scans from index 0.
- Formal/assertion checks: lkp_multi_o never 1 in any run using only this block's insert path; count_o equals popcount(valid bits).

Optional Feature:
CAM_ALLOC_REPLACE_EN
- Defined: insert while full and not duplicate overwrites a victim entry and returns ins_ok_o=1 with the victim's address.
  - The victim is chosen by a round-robin pointer (ADDR_W bits, reset 0), which advances by 1 after each replacement and wraps ENTRIES_N-1 -> 0.
  - count_o stays ENTRIES_N.
  - If the same cycle's delete targets the victim, the insert wins: the entry stays valid with the new key and count is unchanged.
- Undefined: insert while full is rejected as described in Behaviour; no pointer logic is present.

Test Plan:
- Reset, then insert keys 0x11,0x22,0x33 on consecutive cycles -> acks with addrs 0,1,2, ok=1; count_o=3, empty_o=0.
- Insert 0x22 again -> ins_ok_o=0, ins_dup_o=1, ins_addr_o=1, count unchanged; then lookup 0x22 -> hit=1, addr=1, multi=0; lookup 0x44 -> hit=0, addr=0.
- Delete addr 1, then insert 0x55 -> allocated addr 1 (lowest free); lookup 0x22 issued in the same cycle as the delete -> still hit at addr 1.
- Fill all 32 entries -> full_o=1. Insert 0x99 together with delete addr 5 -> insert rejected, count goes 32->31, next insert 0x99 -> addr 5.
- Assert nreset low mid-stream with lkp_i/ins_i active -> all outputs 0 immediately and no ack after release; lookup of a previously inserted key -> miss.
- With CAM_ALLOC_REPLACE_EN on a full table: three inserts of new keys -> addrs 0,1,2 replaced, ok=1, count_o stays 32; old keys at 0..2 then miss.
